// File: rtl/demux_pkg.sv
// Shared route encoding for the demux12_stream slice. The same encoding is
// used by the mux21 selector, so a loopback pairs channel a with s=0.
package demux_pkg;

    localparam logic ROUTE_A = 1'b0;
    localparam logic ROUTE_B = 1'b1;

endpackage

// File: rtl/demux_chan_reg.sv
// One output channel of demux12_stream: a one-entry holding register, its
// valid flag and a wrapping delivered-word counter.
module demux_chan_reg
    import demux_pkg::*;
#(
    parameter int   WIDTH = 1,
    parameter int   CNT_W = 8,
    parameter logic ROUTE = ROUTE_A
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             accept_i,
    input  logic             dst_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             load;
    logic             drain;

    // Next state: a drain empties the slot, a load in the same cycle refills it.
    always_comb begin
        // NOTE: every next-state value starts as a hold so no path leaves it unassigned (no latch).
        data_d  = data_q;
        valid_d = valid_q;
        count_d = count_q;
        load    = accept_i && (dst_i == ROUTE);
        drain   = valid_q && ready_i;
        if (drain) begin
            valid_d = 1'b0;
            count_d = count_q + CNT_W'(1);
        end
        if (load) begin
            data_d  = data_i;
            valid_d = 1'b1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the data register is reset as well so the channel output is never X after reset.
            data_q  <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so all registers update together at the edge.
            data_q  <= data_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign count_o = count_q;

endmodule

// File: rtl/demux12_stream.sv
// Registered 1-to-2 stream demultiplexer. Each accepted word on y is routed to
// channel a or b, chosen by s or by a strict a/b alternation pointer.
module demux12_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8,
    parameter int ALT   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] y,
    input  logic             y_valid,
    output logic             y_ready,
    input  logic             s,
    output logic [WIDTH-1:0] a,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count,
    output logic             sel_q
);

    logic ptr_q, ptr_d;
    logic dst;
    logic dst_valid;
    logic dst_ready;
    logic accept;

    // Destination choice and accept handshake; y_ready never looks at y_valid.
    always_comb begin
        dst       = (ALT != 0) ? ptr_q : s;
        dst_valid = (dst == ROUTE_B) ? b_valid : a_valid;
        dst_ready = (dst == ROUTE_B) ? b_ready : a_ready;
        y_ready   = rst_n && (!dst_valid || dst_ready);
        accept    = y_valid && y_ready;
        sel_q     = dst;
        ptr_d     = ptr_q;
        if ((ALT != 0) && accept) begin
            ptr_d = ~ptr_q;
        end
    end

    // Alternation pointer; advances only on an accepted word, starts at a.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= ROUTE_A;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    demux_chan_reg #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W),
        .ROUTE (ROUTE_A)
    ) u_chan_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .accept_i (accept),
        .dst_i    (dst),
        .data_i   (y),
        .ready_i  (a_ready),
        .data_o   (a),
        .valid_o  (a_valid),
        .count_o  (a_count)
    );

    demux_chan_reg #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W),
        .ROUTE (ROUTE_B)
    ) u_chan_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .accept_i (accept),
        .dst_i    (dst),
        .data_i   (y),
        .ready_i  (b_ready),
        .data_o   (b),
        .valid_o  (b_valid),
        .count_o  (b_count)
    );

endmodule

// File: doc/demux12_stream.md
Name: demux12_stream

Overview:
- Registered 1-to-2 demultiplexer: the receive-side counterpart of the mux21 2:1 selector.
- Takes one valid/ready input stream and routes each accepted word to output channel a or b.
- Routing is by sideband select s (s=0 to a, s=1 to b, the same encoding as mux21) or by automatic alternation.
- Each output channel has a one-entry holding register and a transfer counter. This lets a mux21 upstream and a demux12_stream downstream form a loopback for the Assignment4V bench.

Parameters:
WIDTH, 1, data width of y, a and b
CNT_W, 8, width of per-channel transfer counters
ALT, 0, 0 = route by s; 1 = ignore s and alternate a, b, a, b... starting at a after reset

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
y  in  WIDTH  input data word
y_valid  in  1  input word present
y_ready  out  1  block can accept the word this cycle
s  in  1  route select, sampled with y when y_valid&&y_ready; 0 = a, 1 = b
a  out  WIDTH  channel a data (holding register)
a_valid  out  1  channel a register full
a_ready  in  1  channel a consumer accepts
b  out  WIDTH  channel b data
b_valid  out  1  channel b register full
b_ready  in  1  channel b consumer accepts
a_count  out  CNT_W  words delivered on a (a_valid&&a_ready)
b_count  out  CNT_W  words delivered on b
sel_q  out  1  current destination: s when ALT=0, alternation pointer when ALT=1

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - a, b, a_valid, b_valid, a_count, b_count and the alternation pointer are all 0.
  - y_ready is forced 0 while rst_n=0.
  - Reset mid-transfer discards held words without delivery; counters do not increment.
- Destination: dst = ALT ? ptr : s.
  - sel_q = dst, combinational.
- Accept condition: y_ready = rst_n && (!dst_valid || dst_ready), where dst_valid/dst_ready belong to the channel chosen by dst.
  - Full throughput is possible: a word can be drained and refilled in the same cycle.
  - y_ready depends combinationally on s and on the downstream ready; it never depends on y_valid.
- On accept (y_valid && y_ready):
  - The destination register loads y at the edge; its valid goes to 1.
  - Latency is 1 cycle: the word appears on a/b the cycle after acceptance.
  - The other channel is unaffected.
- Channel drain: x_valid && x_ready with no simultaneous refill clears x_valid. x data holds its last value (not cleared).
- Stability: while x_valid=1 and x_ready=0, x and x_valid hold unchanged (AXI-style; no retraction).
- Counters:
  - x_count increments by 1 on each x_valid && x_ready.
  - They wrap modulo 2^CNT_W: 255 -> 0 for CNT_W=8.
  - Counting is independent of simultaneous refill.
- ALT=1:
  - ptr toggles only on an accepted word.
  - A stall on the pointed channel blocks input even if the other channel is empty (strict order, no skipping).
  - s is ignored.
- Backpressure isolation (ALT=0): a full, stalled channel blocks only words whose s selects it; words selected to the other channel still flow.
- Both channels may be draining in the same cycle; only one can be filled per cycle.

Decomposition:
- Shared package demux_pkg: the route encoding constants ROUTE_A=1'b0 and ROUTE_B=1'b1, shared with mux21 convention checks.
- One natural sub-module: demux_chan_reg. It holds one channel's holding register, valid flag and wrap counter. It is instantiated twice (a, b) with load = accept && dst==its route.
- The top level holds the dst/ptr logic and the y_ready equation.

Test Plan:
- Reset/idle: after reset, a_valid=b_valid=0, counts=0, y_ready=1. Hold rst_n=0 with y_valid=1 for 3 cycles -> y_ready=0, nothing loads.
- Basic routing, ALT=0, WIDTH=1, ready=1: send y=1 with s=0, then y=0 with s=1, then y=1 with s=1. Expected:
  - a=1 valid one cycle after the first word, then b=0, then b=1.
  - a_count=1, b_count=2.
- Backpressure isolation: a_ready=0, b_ready=1.
  - Send s=0 y=1 -> a_valid stays 1 and holds.
  - A second s=0 word -> y_ready=0.
  - An s=1 word is accepted -> b valid next cycle.
  - Release a_ready -> a_count=1, queued s=0 word accepted the same cycle.
- Full throughput: both readies=1, y_valid=1 every cycle for 10 cycles, s alternating -> 10 accepts, a_count=5, b_count=5, no bubble.
- ALT=1 ordering: 4 words 1,0,1,1 with s=1 constant -> a gets 1,1 and b gets 0,1. With b_ready=0 while ptr=b -> y_ready=0 although a is empty.
- Wrap and reset mid-op: CNT_W=2, deliver 5 words on a -> a_count=1. Assert rst_n=0 while b_valid=1 -> next cycle b_valid=0, b_count=0, ptr=0.
